// File: rtl/cb_cfg_pkg.sv
// Shared types and elaboration-time helpers for the CB-Y connection block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cb_cfg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cb_state_e;

    // Select width holds every legal input index plus one spare code point,
    // so at least one select value always means "drive 0".
    function automatic int calc_sel_w(input int mux_size);
        return $clog2(mux_size) + 1;
    endfunction

    function automatic int calc_chain_len(input int num_ipin, input int mux_size);
        return num_ipin * calc_sel_w(mux_size);
    endfunction

    // Track feeding input pair 'pair' of ipin 'ipin'. Successive pairs step
    // 'stride' tracks apart and wrap around the channel.
    function automatic int track_idx(input int ipin, input int pair,
                                     input int stride, input int chan_w);
        return (ipin + pair * stride) % chan_w;
    endfunction

endpackage

// File: rtl/cb_ipin_mux.sv
// One grid-pin selector: picks one of MUX_SIZE inputs or drives 0.
// Latency: combinational.
// Backpressure: none.
module cb_ipin_mux #(
    parameter int MUX_SIZE = 8,
    parameter int SEL_W    = 4
) (
    input  logic [MUX_SIZE-1:0] in_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic                en_i,
    output logic                out_o
);

    localparam int IDX_W = $clog2(MUX_SIZE);

    // Out-of-range selects and a disabled block both park the pin low.
    always_comb begin
        out_o = 1'b0;
        if (en_i && (sel_i < SEL_W'(MUX_SIZE))) begin
            out_o = in_i[sel_i[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/cby_param_shadow.sv
// CB-Y connection block: pass-through tracks plus ipin muxes with a shadowed config chain.
// Latency: tracks/ipins combinational; new config live on the edge after enable drops.
// Backpressure: none; the serial stream is accepted one bit per enabled prog_clk edge.
module cby_param_shadow
    import cb_cfg_pkg::*;
#(
    parameter int CHAN_W   = 20,
    parameter int NUM_IPIN = 9,
    parameter int MUX_SIZE = 8,
    parameter int STRIDE   = 4
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                config_enable,
    input  logic                ccff_head,
    output logic                ccff_tail,
    input  logic [CHAN_W-1:0]   chany_bottom_in,
    input  logic [CHAN_W-1:0]   chany_top_in,
    output logic [CHAN_W-1:0]   chany_top_out,
    output logic [CHAN_W-1:0]   chany_bottom_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                config_valid,
    output logic                config_error
);

    localparam int SEL_W     = calc_sel_w(MUX_SIZE);
    localparam int CHAIN_LEN = calc_chain_len(NUM_IPIN, MUX_SIZE);
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

    cb_state_e              state_q,  state_d;
    logic [CHAIN_LEN-1:0]   shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0]   active_q, active_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   valid_q,  valid_d;
    logic                   error_q,  error_d;

    // Tracks are plain wires: no dependence on configuration or reset.
    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;

    assign ccff_tail    = shadow_q[CHAIN_LEN-1];
    assign config_valid = valid_q;
    assign config_error = error_q;

    // Next-state: shift while enabled; on the falling enable, commit only an exact-length load.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        bit_cnt_d = bit_cnt_q;
        valid_d   = valid_q;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (config_enable) begin
                    shadow_d  = {shadow_q[CHAIN_LEN-2:0], ccff_head};
                    bit_cnt_d = CNT_W'(1);
                    error_d   = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (config_enable) begin
                    shadow_d = {shadow_q[CHAIN_LEN-2:0], ccff_head};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (bit_cnt_q == CNT_FULL) begin
                        active_d = shadow_q;
                        valid_d  = 1'b1;
                    end else begin
                        // A wrong-length load leaves the previous routing in place.
                        error_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State register; reset clears both chains so pins drop to 0 immediately.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            active_q  <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
        logic [MUX_SIZE-1:0] mux_in;

        // Even inputs come from below, odd from above, on the same track of each pair.
        for (genvar gj = 0; gj < MUX_SIZE; gj++) begin : g_in
            if (gj % 2 == 0) begin : g_bot
                assign mux_in[gj] = chany_bottom_in[track_idx(gi, gj / 2, STRIDE, CHAN_W)];
            end else begin : g_top
                assign mux_in[gj] = chany_top_in[track_idx(gi, gj / 2, STRIDE, CHAN_W)];
            end
        end

        cb_ipin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_mux (
            .in_i  (mux_in),
            .sel_i (active_q[gi*SEL_W +: SEL_W]),
            .en_i  (valid_q),
            .out_o (ipin_out[gi])
        );
    end

endmodule

// File: tb/tb_cby_param_shadow.sv
// Directed bench for cby_param_shadow with a bit-history reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cby_param_shadow;

    localparam int CHAN_W    = 20;
    localparam int NUM_IPIN  = 9;
    localparam int MUX_SIZE  = 8;
    localparam int STRIDE    = 4;
    localparam int SEL_W     = 4;
    localparam int CHAIN_LEN = 36;

    logic                prog_clk = 1'b0;
    logic                pReset;
    logic                config_enable;
    logic                ccff_head;
    logic                ccff_tail;
    logic [CHAN_W-1:0]   bin;
    logic [CHAN_W-1:0]   tin;
    logic [CHAN_W-1:0]   tout;
    logic [CHAN_W-1:0]   bout;
    logic [NUM_IPIN-1:0] ipin;
    logic                cv;
    logic                ce;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b1;

    cby_param_shadow #(
        .CHAN_W   (CHAN_W),
        .NUM_IPIN (NUM_IPIN),
        .MUX_SIZE (MUX_SIZE),
        .STRIDE   (STRIDE)
    ) dut (
        .prog_clk         (prog_clk),
        .pReset           (pReset),
        .config_enable    (config_enable),
        .ccff_head        (ccff_head),
        .ccff_tail        (ccff_tail),
        .chany_bottom_in  (bin),
        .chany_top_in     (tin),
        .chany_top_out    (tout),
        .chany_bottom_out (bout),
        .ipin_out         (ipin),
        .config_valid     (cv),
        .config_error     (ce)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every bit shifted since reset, the length of the
    // current enable pulse, and the decoded selects of the live config.
    bit m_bits[$];
    int m_cnt   = 0;
    bit m_in    = 1'b0;
    int m_sel[NUM_IPIN];
    bit m_valid = 1'b0;
    bit m_err   = 1'b0;

    always @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            m_bits.delete();
            m_cnt   = 0;
            m_in    = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            foreach (m_sel[i]) m_sel[i] = 0;
        end else if (config_enable) begin
            if (!m_in) begin
                m_in  = 1'b1;
                m_cnt = 0;
                m_err = 1'b0;
            end
            m_bits.push_back(ccff_head);
            m_cnt++;
        end else if (m_in) begin
            m_in = 1'b0;
            if (m_cnt == CHAIN_LEN) begin
                int sz;
                sz = m_bits.size();
                m_valid = 1'b1;
                // Config bit n is the bit shifted n edges before the last one.
                for (int i = 0; i < NUM_IPIN; i++) begin
                    m_sel[i] = 0;
                    for (int b = 0; b < SEL_W; b++) begin
                        if (m_bits[sz - 1 - (i * SEL_W + b)]) m_sel[i] += (1 << b);
                    end
                end
            end else begin
                m_err = 1'b1;
            end
        end
    end

    function automatic logic [NUM_IPIN-1:0] exp_ipin();
        logic [NUM_IPIN-1:0] r;
        int t;
        r = '0;
        for (int i = 0; i < NUM_IPIN; i++) begin
            if (m_valid && m_sel[i] < MUX_SIZE) begin
                t = (i + (m_sel[i] / 2) * STRIDE) % CHAN_W;
                r[i] = (m_sel[i] % 2 == 1) ? tin[t] : bin[t];
            end
        end
        return r;
    endfunction

    function automatic logic exp_tail();
        int sz;
        sz = m_bits.size();
        return (sz >= CHAIN_LEN) ? m_bits[sz - CHAIN_LEN] : 1'b0;
    endfunction

    always @(negedge prog_clk) begin
        if (cmp_on) begin
            chk("ipin_out", 32'(ipin), 32'(exp_ipin()));
            chk("config_valid", 32'(cv), 32'(m_valid));
            chk("config_error", 32'(ce), 32'(m_err));
            chk("ccff_tail", 32'(ccff_tail), 32'(exp_tail()));
            chk("chany_top_out", 32'(tout), 32'(bin));
            chk("chany_bottom_out", 32'(bout), 32'(tin));
        end
    end

    // Shift n bits of cfg (MSB first, zeros past 36), optionally dropping enable after.
    task automatic load(input logic [CHAIN_LEN-1:0] cfg, input int n, input bit drop, input bit tog);
        for (int idx = 0; idx < n; idx++) begin
            config_enable = 1'b1;
            ccff_head = (idx < CHAIN_LEN) ? cfg[CHAIN_LEN - 1 - idx] : 1'b0;
            if (tog) begin
                tin = CHAN_W'($urandom);
                bin = CHAN_W'($urandom);
            end
            @(posedge prog_clk); #2;
        end
        if (drop) begin
            config_enable = 1'b0;
            @(posedge prog_clk); #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [CHAIN_LEN-1:0] cfg_a;
        logic [CHAIN_LEN-1:0] cfg_c;
        logic [40:0]          pat;

        cfg_a = {NUM_IPIN{4'hF}};
        cfg_a[2*SEL_W +: SEL_W] = 4'd3;          // ipin2 <- top_in[6]
        cfg_c = {NUM_IPIN{4'h8}};
        cfg_c[0*SEL_W +: SEL_W] = 4'd0;          // ipin0 <- bottom_in[0]
        cfg_c[1*SEL_W +: SEL_W] = 4'd9;          // out of range -> 0
        cfg_c[5*SEL_W +: SEL_W] = 4'd4;          // ipin5 <- bottom_in[13]
        cfg_c[8*SEL_W +: SEL_W] = 4'd7;          // ipin8 <- top_in[0]
        pat = {5'b10110, 36'h5A3C96E1D};

        pReset = 1'b1; config_enable = 1'b0; ccff_head = 1'b0;
        tin = '0; bin = '0;

        // Reset held with tracks toggling.
        repeat (4) begin
            @(posedge prog_clk); #2;
            tin = CHAN_W'($urandom);
            bin = CHAN_W'($urandom);
            #1;
            chk("rst_ipin", 32'(ipin), 32'h0);
            chk("rst_valid", 32'(cv), 32'h0);
            chk("rst_tail", 32'(ccff_tail), 32'h0);
            chk("rst_passthru", 32'(tout), 32'(bin));
        end
        pReset = 1'b0;
        @(posedge prog_clk); #2;

        // Short load from reset.
        load(cfg_a, 35, 1'b1, 1'b1);
        chk("short_error", 32'(ce), 32'h1);
        chk("short_valid", 32'(cv), 32'h0);
        tin = '1; bin = '1; #1;
        chk("short_ipin", 32'(ipin), 32'h0);

        // Exact load: only ipin2 live, following top_in[6].
        load(cfg_a, 36, 1'b1, 1'b1);
        tin = '0; tin[6] = 1'b1; bin = '1; #1;
        chk("a_ipin_hi", 32'(ipin), 32'h004);
        chk("a_valid", 32'(cv), 32'h1);
        chk("a_error", 32'(ce), 32'h0);
        tin[6] = 1'b0; #1;
        chk("a_ipin_lo", 32'(ipin), 32'h0);

        // Overlong load: old routing stays live during and after.
        load(cfg_c, 37, 1'b1, 1'b1);
        chk("long_error", 32'(ce), 32'h1);
        chk("long_valid", 32'(cv), 32'h1);
        tin = '0; tin[6] = 1'b1; bin = '0; #1;
        chk("long_ipin", 32'(ipin), 32'h004);

        // Reset mid-load at bit 20.
        load(cfg_c, 20, 1'b0, 1'b1);
        pReset = 1'b1; config_enable = 1'b0; #1;
        chk("midrst_ipin", 32'(ipin), 32'h0);
        chk("midrst_valid", 32'(cv), 32'h0);
        @(posedge prog_clk); #2;
        pReset = 1'b0;
        @(posedge prog_clk); #2;

        // Fresh exact load after reset.
        load(cfg_c, 36, 1'b1, 1'b0);
        tin = '0; bin = '0; bin[0] = 1'b1; bin[13] = 1'b1; #1;
        chk("c_ipin_bot", 32'(ipin), 32'h021);
        tin[0] = 1'b1; bin = '0; #1;
        chk("c_ipin_top", 32'(ipin), 32'h100);
        chk("c_valid", 32'(cv), 32'h1);

        // 41-bit stream: tail replays the head 36 edges later.
        for (int idx = 0; idx < 41; idx++) begin
            config_enable = 1'b1;
            ccff_head = pat[40 - idx];
            @(posedge prog_clk); #2;
            if (idx >= CHAIN_LEN - 1) begin
                chk("tail_replay", 32'(ccff_tail), 32'(pat[40 - (idx - (CHAIN_LEN - 1))]));
            end
        end
        config_enable = 1'b0;
        @(posedge prog_clk); #2;
        chk("tail_error", 32'(ce), 32'h1);

        repeat (2) @(posedge prog_clk);
        #2;
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cby_param_shadow.md
Name: cby_param_shadow

Overview:
- Parametrised Y-direction connection block (CB-Y) with a double-buffered configuration chain.
- Routes CHAN_W vertical tracks straight through in both directions.
- Drives NUM_IPIN grid input pins through configurable MUX_SIZE-input selectors.
- Configuration shifts into a shadow chain while the active selects keep driving. It commits atomically only when exactly the right number of bits has been shifted, so a short or long load never glitches the routing or leaves it half-loaded.

Parameters:
- CHAN_W, 20, tracks per direction.
- NUM_IPIN, 9, grid input pins driven.
- MUX_SIZE, 8, inputs per ipin mux; must be even and ≤ 2*CHAN_W.
- STRIDE, 4, track spacing between consecutive mux input pairs.
- SEL_W (derived), $clog2(MUX_SIZE)+1, select bits per mux.
- CHAIN_LEN (derived), NUM_IPIN*SEL_W, configuration bits.

Ports:
- prog_clk  in  1  configuration clock, the only clock in the block.
- pReset  in  1  asynchronous, active-high reset.
- config_enable  in  1  high = shift one bit per prog_clk rising edge.
- ccff_head  in  1  serial configuration input.
- ccff_tail  out  1  serial output, equal to shadow bit CHAIN_LEN-1.
- chany_bottom_in  in  CHAN_W  tracks entering from below.
- chany_top_in  in  CHAN_W  tracks entering from above.
- chany_top_out  out  CHAN_W  equals chany_bottom_in (combinational).
- chany_bottom_out  out  CHAN_W  equals chany_top_in (combinational).
- ipin_out  out  NUM_IPIN  grid pin drives.
- config_valid  out  1  an active configuration is loaded.
- config_error  out  1  the last load had the wrong bit count.

Behaviour:
- Clock and reset: single clock prog_clk; reset pReset is asynchronous and active-high.
- Reset values:
  - shadow register = 0, active register = 0, bit_cnt = 0, state = IDLE.
  - config_valid = 0, config_error = 0, ccff_tail = 0.
  - ipin_out = 0 while reset is held.
- Shadow chain:
  - On each prog_clk edge with config_enable=1: shadow <= {shadow[CHAIN_LEN-2:0], ccff_head}.
  - The first bit shifted in ends at index CHAIN_LEN-1.
  - Mux i select = active[i*SEL_W +: SEL_W].
- bit_cnt:
  - Increments on each shift and saturates at CHAIN_LEN+1.
  - Width is $clog2(CHAIN_LEN+2).
- FSM, two states:
  - IDLE, config_enable=1: go to SHIFT; this edge shifts, bit_cnt <= 1, config_error <= 0.
  - SHIFT, config_enable=1: shift, bit_cnt += 1 (saturating).
  - SHIFT, config_enable=0:
    - If bit_cnt == CHAIN_LEN: active <= shadow, config_valid <= 1.
    - Otherwise: active unchanged, config_error <= 1.
    - In both cases go to IDLE and clear bit_cnt.
- Shadow register behaviour:
  - It is unchanged in IDLE.
  - The active configuration keeps driving ipin_out unchanged throughout SHIFT.
  - A new value is visible on ipin_out immediately after the commit edge, one cycle after the last shift.
- Mux mapping for ipin i, input j:
  - k = j/2; track t = (i + k*STRIDE) mod CHAN_W.
  - Even j selects chany_bottom_in[t]; odd j selects chany_top_in[t].
- Select decode:
  - sel < MUX_SIZE: ipin_out[i] = selected input.
  - sel ≥ MUX_SIZE: ipin_out[i] = 0.
  - config_valid = 0 forces all ipin_out = 0.
  - The decode is combinational from the active register.
- Boundary cases:
  - A zero-length pulse is impossible, since every pulse includes at least one shift.
  - An overlong load saturates bit_cnt at CHAIN_LEN+1, which is an error.
  - A failed load does not clear config_valid; the prior configuration stays live.
  - pReset asserted mid-shift returns the block to the reset state; ipin_out goes to 0 asynchronously.
- Pass-through tracks ignore configuration and reset.

Decomposition:
- Shared package (cb_cfg_pkg):
  - state enum {IDLE, SHIFT};
  - a constant function computing SEL_W and CHAIN_LEN;
  - a constant function computing the track-index mapping.
- Sub-module: cb_ipin_mux, parametrised by MUX_SIZE, SEL_W, with ports in, sel, en → out. It is instantiated NUM_IPIN times.
- Chain, counter and FSM stay in the top level.

Test Plan:
- Reset with chany inputs toggling → ipin_out=0, config_valid=0, ccff_tail=0; chany_top_out tracks chany_bottom_in.
- Shift 36 bits with config_enable high, setting ipin 2 sel=3 and all other sels=15, then drop enable. Required response:
  - ipin_out[2] follows chany_top_in[6] from the edge after the drop; all other ipins read 0.
  - config_valid=1.
- Shift 35 bits then drop enable → config_error=1, config_valid=0, ipin_out remains 0.
- Load a valid configuration, then shift 37 bits while toggling chany_top_in[6] → ipin_out[2] keeps following top_in[6] during the shift; afterwards config_error=1 and the active configuration is unchanged.
- Mid-way through a valid load (bit 20), assert pReset for one cycle → all state clears, config_valid=0; a subsequent full 36-bit load commits normally.
- Shift a known pattern of 36+5 bits → ccff_tail reproduces ccff_head delayed by 36 edges.
